mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide engine that produces the 64-bit result written into the HI/LO `register64`. The 64-bit result drives `register64.D` and the one-cycle write strobe drives `register64.input_enable`. Multiplication uses radix-2 shift-add and division uses restoring shift-subtract, one bit per cycle. It sits beside the ALU in the execute stage and is controlled by a start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand width; the result is 2*WIDTH.

- `clk` in 1: rising-edge clock.
- `clr` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when the unit can accept.
- `op` in 2: operation code.
  - 00 MULTU
  - 01 MULT
  - 10 DIVU
  - 11 DIV
- `a` in WIDTH: multiplicand or dividend; captured on accept.
- `b` in WIDTH: multiplier or divisor; captured on accept.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when `result` is valid.
- `wr_en` out 1: one-cycle write strobe to the HI/LO register; identical timing to `done`.
- `result` out 2*WIDTH: output value.
  - Multiply: the product.
  - Divide: {remainder, quotient}, so HI = remainder and LO = quotient.
- `div_by_zero` out 1: valid with `done`; high for a divide with `b`==0.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - `start`=1 captures `op`, `a` and `b`, then moves to PREP.
  - Otherwise stays in IDLE.
- PREP:
  - For signed ops, records the operand signs and replaces each operand with its absolute value (two's-complement negate when negative).
  - Clears the accumulator and loads iteration count 0.
  - Moves to ITER.
- ITER, 32 cycles, count 0..31:
  - Multiply: when the multiplier LSB is 1, add the multiplicand to the upper accumulator half, then shift the 64-bit {acc, multiplier} right by 1, keeping the carry.
  - Divide: shift {rem, quo} left by 1, compute rem-b, and on no borrow keep the difference and set quo LSB to 1.
  - Moves to FIX after count 31.
- FIX:
  - Applies sign correction.
    - Product: negated when sign(a) xor sign(b).
    - Quotient: negated when sign(a) xor sign(b).
    - Remainder: takes the sign of `a`.
  - Registers `result` and moves to DONE.
- DONE:
  - `done`=1 and `wr_en`=1 for this cycle only.
  - `start`=1 in this cycle is accepted (go to PREP); otherwise go to IDLE.
- Divide by zero:
  - Full latency is preserved.
  - `result` = {a_original, 32'hFFFFFFFF}.
  - `div_by_zero`=1.
- Signed overflow, 0x80000000 / 0xFFFFFFFF under DIV:
  - Quotient = 0x80000000, remainder = 0, `div_by_zero`=0.
  - This is the natural result of the unsigned datapath and is not trapped.
- `result` holds its value until the next FIX; `div_by_zero` holds until the next accept.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `wr_en`=0, `result`=0, `div_by_zero`=0.
- Latency, with `start` accepted at clock edge N:
  - PREP during cycle N..N+1.
  - ITER over edges N+2..N+33.
  - FIX at edge N+34.
  - `done`/`wr_en` high for the cycle following edge N+34 (34-cycle latency).
- `busy` is 1 in PREP, ITER and FIX, and 0 in IDLE and DONE.
- Back-to-back operation gives one result per 35 cycles.
- `start` while `busy`=1 is ignored: no queuing and no effect on the current operation.
- Changes on `a`, `b` or `op` after accept have no effect.
- Reset asserted mid-operation:
  - Immediately forces state IDLE and all outputs to reset values.
  - No `wr_en` pulse is produced for the aborted operation.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT and DIV perform signed arithmetic as described above.
- `MULDIV_SIGNED_EN` undefined:
  - `op[0]` is ignored, so all operations are unsigned.
  - PREP sign handling and FIX negation logic are removed; FIX only registers `result`.
  - Latency is unchanged.

## Test plan
- Reset, then MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF:
  - After 34 cycles `result`=0xFFFFFFFE00000001.
  - `done`/`wr_en` high for exactly 1 cycle.
- MULT `a`=0xFFFFFFFD (-3), `b`=7:
  - `result`=0xFFFFFFFFFFFFFFEB (-21).
  - Without `MULDIV_SIGNED_EN`: `result`=0x00000006FFFFFFEB.
- DIVU `a`=100, `b`=7:
  - `result`=0x000000020000000E (HI=2, LO=14).
- DIV `a`=-100, `b`=7:
  - HI=0xFFFFFFFE (-2), LO=0xFFFFFFF2 (-14).
- DIVU `a`=0x12345678, `b`=0:
  - `result`=0x12345678FFFFFFFF, `div_by_zero`=1 with `done`.
- `start` pulsed again at cycle 10 of a running MULTU:
  - Ignored; exactly one `done` occurs.
- Reset at cycle 20 of a DIVU:
  - `busy`=0 immediately; no `wr_en` afterwards; `result`=0.
- New `start` during the DONE cycle:
  - Accepted; the next `done` arrives 34 cycles later.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide engine that produces the HI/LO result: radix-2 shift-add multiply and restoring divide.
// Build option: define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise op[0] is ignored and every op is unsigned.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               wr_en,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_e;

    state_e               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef MULDIV_SIGNED_EN
    logic                 sgn_q, sgn_d;
`endif

    logic                 accept_c;
    logic [WIDTH:0]       sum_c;
    logic [WIDTH:0]       rsh_c;
    logic [WIDTH:0]       diff_c;
    logic [WIDTH-1:0]     a_abs_c, b_abs_c;
    logic [2*WIDTH-1:0]   fixed_c;

    // Iteration datapath: mul adds into the upper half, div trial-subtracts the shifted remainder
    always_comb begin
        sum_c  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
        rsh_c  = {acc_q, lo_q[WIDTH-1]};
        diff_c = rsh_c - {1'b0, opnd_q};
    end

    // Magnitude conversion on entry and sign restoration on exit
    always_comb begin
        a_abs_c = a_q;
        b_abs_c = b_q;
        fixed_c = {acc_q, lo_q};
`ifdef MULDIV_SIGNED_EN
        if (sgn_q && a_q[WIDTH-1]) a_abs_c = ~a_q + WIDTH'(1);
        if (sgn_q && b_q[WIDTH-1]) b_abs_c = ~b_q + WIDTH'(1);
        if (sgn_q) begin
            if (!is_div_q) begin
                if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) fixed_c = ~{acc_q, lo_q} + (2*WIDTH)'(1);
            end else begin
                if (a_q[WIDTH-1]) fixed_c[2*WIDTH-1:WIDTH] = ~acc_q + WIDTH'(1);
                if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) fixed_c[WIDTH-1:0] = ~lo_q + WIDTH'(1);
            end
        end
`endif
    end

    assign accept_c = start && (state_q == S_IDLE || state_q == S_DONE);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
`ifdef MULDIV_SIGNED_EN
        sgn_d    = sgn_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    is_div_d = op[1];
`ifdef MULDIV_SIGNED_EN
                    sgn_d    = op[0];
`endif
                    a_d      = a;
                    b_d      = b;
                    dbz_d    = 1'b0;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                acc_d   = '0;
                cnt_d   = '0;
                opnd_d  = is_div_q ? b_abs_c : a_abs_c;
                lo_d    = is_div_q ? a_abs_c : b_abs_c;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (is_div_q) begin
                    if (!diff_c[WIDTH]) begin
                        acc_d = diff_c[WIDTH-1:0];
                        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rsh_c[WIDTH-1:0];
                        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = sum_c[WIDTH:1];
                    lo_d  = {sum_c[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                dbz_d    = is_div_q && (b_q == '0);
                result_d = (is_div_q && (b_q == '0)) ? {a_q, {WIDTH{1'b1}}} : fixed_c;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_PREP) || (state_d == S_ITER) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= sgn_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign wr_en       = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: vector table plus abort, ignored-start and back-to-back sequences.
// Expectations follow the MULDIV_SIGNED_EN setting used for the build.
module tb_mul_div_unit;

`ifdef MULDIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, wr_en, div_by_zero;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .wr_en(wr_en), .result(result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept at edge N; returns #1 after that edge with inputs scrambled
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = ~x; b = ~y;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    int cyc;
    int cnt;

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'd7,
                     SGN ? 64'hFFFFFFFF_FFFFFFEB : 64'h00000006_FFFFFFEB, 1'b0};
        vecs[2]  = '{2'b10, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0};
        vecs[3]  = '{2'b11, 32'hFFFFFF9C, 32'd7,
                     SGN ? 64'hFFFFFFFE_FFFFFFF2 : 64'h00000002_24924916, 1'b0};
        vecs[4]  = '{2'b10, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, 1'b1};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF,
                     SGN ? 64'h00000000_80000000 : 64'h80000000_00000000, 1'b0};
        vecs[6]  = '{2'b00, 32'd0, 32'h00012345, 64'h0, 1'b0};
        vecs[7]  = '{2'b00, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b0};
        vecs[8]  = '{2'b11, 32'hFFFFFF9C, 32'd0, 64'hFFFFFF9C_FFFFFFFF, 1'b1};
        vecs[9]  = '{2'b10, 32'd7, 32'd100, 64'h00000007_00000000, 1'b0};
        vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     SGN ? 64'h00000000_00000001 : 64'hFFFFFFFE_00000001, 1'b0};
        vecs[11] = '{2'b11, 32'd100, 32'hFFFFFFF9,
                     SGN ? 64'h00000002_FFFFFFF2 : 64'h00000064_00000000, 1'b0};

        clr = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   64'(busy), 64'd0);
        chk("reset_done",   64'(done), 64'd0);
        chk("reset_wr_en",  64'(wr_en), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_dbz",    64'(div_by_zero), 64'd0);
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy_prep", i), 64'(busy), 64'd1);
            wait_done(cyc);
            chk($sformatf("v%0d_latency", i), 64'(cyc), 64'd34);
            chk($sformatf("v%0d_result", i), result, vecs[i].exp);
            chk($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].dbz));
            chk($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'd1);
            chk($sformatf("v%0d_busy_done", i), 64'(busy), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("v%0d_result_hold", i), result, vecs[i].exp);
            chk($sformatf("v%0d_dbz_hold", i), 64'(div_by_zero), 64'(vecs[i].dbz));
        end

        // start pulsed mid-operation is ignored
        start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #1;
        op = 2'b10; a = 32'd5; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (done === 1'b1) begin
                cnt++;
                chk("ignore_start_result", result, 64'hFFFFFFFE_00000001);
            end
            @(posedge clk); #1;
        end
        chk("ignore_start_done_count", 64'(cnt), 64'd1);

        // reset at cycle 20 of a DIVU
        start_op(2'b10, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("abort_busy",   64'(busy), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_done",   64'(done), 64'd0);
        @(negedge clk);
        clr = 1'b1;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (wr_en === 1'b1) cnt++;
        end
        chk("abort_no_wr_en", 64'(cnt), 64'd0);
        chk("abort_result_after", result, 64'd0);

        // start accepted during the DONE cycle
        start_op(2'b10, 32'd100, 32'd7);
        wait_done(cyc);
        chk("b2b_first_latency", 64'(cyc), 64'd34);
        chk("b2b_first_result", result, 64'h00000002_0000000E);
        op = 2'b00; a = 32'h00010000; b = 32'h00010000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = '0; b = '0;
        chk("b2b_busy_after_accept", 64'(busy), 64'd1);
        wait_done(cyc);
        chk("b2b_second_latency", 64'(cyc), 64'd34);
        chk("b2b_second_result", result, 64'h00000001_00000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
